// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - shared types and truth-table constants for the gate BIST
// Purpose: sequencer state encoding and expected-output tables for common
//          2-input gates. Bit k of a table is the gate output for {a,b} = k.
package gate_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bist_state_e;

  localparam int unsigned CNT_W = 4;

  localparam logic [3:0] TT_AND   = 4'b1000;
  localparam logic [3:0] TT_OR    = 4'b1110;
  localparam logic [3:0] TT_XOR   = 4'b0110;
  localparam logic [3:0] TT_NAND  = 4'b0111;
  localparam logic [3:0] TT_NOT_A = 4'b0011;

endpackage

// File: rtl/bist_settle_cnt.sv
// rtl/bist_settle_cnt.sv - modulo-SETTLE hold counter for the gate BIST
// Purpose: counts 0..SETTLE-1 while enabled and wraps; last_o flags the
//          final count so the sequencer samples on that edge.
// Ports:
//   clk    in  clock
//   rst    in  synchronous active-high reset
//   clr_i  in  force count to 0 (takes effect on the next edge)
//   en_i   in  advance the count
//   last_o out high while the count equals SETTLE-1
module bist_settle_cnt
  import gate_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == LAST);

endmodule

// File: rtl/gate_bist.sv
// rtl/gate_bist.sv - built-in self-test sequencer for a 2-input gate
// Purpose: drives the four {a,b} vectors into the gate under test, holds each
//          for SETTLE cycles, compares the sampled response with TRUTH and
//          reports pass, mismatch count and a per-vector failure map.
// Ports:
//   clk        in  clock
//   rst        in  synchronous active-high reset
//   start      in  begin a sweep (honoured in IDLE and DONE only)
//   a, b       out registered gate inputs, {a,b} = vector index
//   out_dut    in  gate-under-test response
//   busy       out sweep in progress
//   done       out sweep finished, held until next start or rst
//   pass       out done with no mismatches
//   err_count  out number of mismatching vectors
//   fail_vec   out bit k set iff vector k mismatched
module gate_bist
  import gate_pkg::*;
#(
  parameter logic [3:0]  TRUTH  = 4'b1110,
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       out_dut,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  bist_state_e state_q;
  logic [1:0]  idx_q;
  logic        a_q, b_q, busy_q, done_q, pass_q;
  logic [2:0]  err_q;
  logic [3:0]  fail_q;

  logic        cnt_last;
  logic        mismatch;
  logic [2:0]  err_d;

  // The counter is held at 0 outside RUN so every sweep starts a fresh hold.
  bist_settle_cnt #(
    .SETTLE (SETTLE)
  ) u_settle_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q != RUN),
    .en_i   (state_q == RUN),
    .last_o (cnt_last)
  );

  // Case inequality so an X/Z response in simulation is reported as a failure.
  assign mismatch = (out_dut !== TRUTH[idx_q]);
  assign err_d    = err_q + {2'b00, mismatch};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      fail_q  <= 4'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q    <= RUN;
            idx_q      <= 2'd0;
            {a_q, b_q} <= 2'b00;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= 3'd0;
            fail_q     <= 4'd0;
          end
        end
        RUN: begin
          if (cnt_last) begin
            err_q <= err_d;
            if (mismatch) begin
              fail_q[idx_q] <= 1'b1;
            end
            if (idx_q == 2'd3) begin
              state_q    <= DONE;
              {a_q, b_q} <= 2'b00;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              pass_q     <= (err_d == 3'd0);
            end else begin
              // Next vector is driven on the same edge the current one is sampled.
              idx_q      <= idx_q + 2'd1;
              {a_q, b_q} <= idx_q + 2'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_bist.sv
// tb/tb_gate_bist.sv - directed self-checking bench for gate_bist
module tb_gate_bist;
  import gate_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // DUT 1: TRUTH=OR, SETTLE=1, gate selectable between OR and AND
  logic start1 = 1'b0, gsel = 1'b0;
  logic a1, b1, out1, busy1, done1, pass1;
  logic [2:0] err1;
  logic [3:0] fv1;
  assign out1 = gsel ? (a1 & b1) : (a1 | b1);

  gate_bist #(.TRUTH(TT_OR), .SETTLE(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .out_dut(out1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fv1));

  // DUT 3: TRUTH=OR, SETTLE=3, output tied low
  logic start3 = 1'b0;
  logic a3, b3, busy3, done3, pass3;
  logic [2:0] err3;
  logic [3:0] fv3;

  gate_bist #(.TRUTH(TT_OR), .SETTLE(3)) u_d3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .out_dut(1'b0),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .fail_vec(fv3));

  // DUTs 2x/2n: SETTLE=2, both with an XOR gate, expecting XOR and NAND
  logic start2 = 1'b0;
  logic ax, bx, busyx, donex, passx;
  logic [2:0] errx;
  logic [3:0] fvx;
  logic an, bn, busyn, donen, passn;
  logic [2:0] errn;
  logic [3:0] fvn;

  gate_bist #(.TRUTH(TT_XOR), .SETTLE(2)) u_d2x (
    .clk(clk), .rst(rst), .start(start2), .a(ax), .b(bx), .out_dut(ax ^ bx),
    .busy(busyx), .done(donex), .pass(passx), .err_count(errx), .fail_vec(fvx));

  gate_bist #(.TRUTH(TT_NAND), .SETTLE(2)) u_d2n (
    .clk(clk), .rst(rst), .start(start2), .a(an), .b(bn), .out_dut(an ^ bn),
    .busy(busyn), .done(donen), .pass(passn), .err_count(errn), .fail_vec(fvn));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int busy_cnt;
  logic done_at11, done_at12;

  initial begin
    // Reset
    rst = 1'b1;
    step();
    step();
    chk("rst_ab", {6'b0, a1, b1}, 8'h00);
    chk("rst_busy", {7'b0, busy1}, 8'h00);
    chk("rst_done", {7'b0, done1}, 8'h00);
    chk("rst_pass", {7'b0, pass1}, 8'h00);
    chk("rst_err", {5'b0, err1}, 8'h00);
    chk("rst_fail", {4'b0, fv1}, 8'h00);
    rst = 1'b0;
    step();
    chk("idle_stays", {7'b0, busy1}, 8'h00);

    // OR gate, SETTLE=1: vectors on consecutive cycles, done 4 cycles after start
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("or_v0_ab", {6'b0, a1, b1}, 8'h00);
    chk("or_busy", {7'b0, busy1}, 8'h01);
    for (int k = 1; k < 4; k++) begin
      step();
      chk("or_vk_ab", {6'b0, a1, b1}, 8'(k));
      chk("or_not_done", {7'b0, done1}, 8'h00);
    end
    step();
    chk("or_done", {7'b0, done1}, 8'h01);
    chk("or_pass", {7'b0, pass1}, 8'h01);
    chk("or_err", {5'b0, err1}, 8'h00);
    chk("or_fail", {4'b0, fv1}, 8'h00);
    chk("or_busy_low", {7'b0, busy1}, 8'h00);
    chk("or_ab_rest", {6'b0, a1, b1}, 8'h00);
    step();
    chk("or_done_hold", {7'b0, done1}, 8'h01);

    // AND gate against OR table, with start held high through RUN
    gsel = 1'b1;
    start1 = 1'b1;
    step();
    for (int k = 1; k < 4; k++) begin
      step();
      chk("hold_ab", {6'b0, a1, b1}, 8'(k));
    end
    step();
    chk("and_done", {7'b0, done1}, 8'h01);
    chk("and_pass", {7'b0, pass1}, 8'h00);
    chk("and_err", {5'b0, err1}, 8'h02);
    chk("and_fail", {4'b0, fv1}, 8'h06);
    // start still high in DONE: restart on this edge
    step();
    start1 = 1'b0;
    chk("restart_done", {7'b0, done1}, 8'h00);
    chk("restart_pass", {7'b0, pass1}, 8'h00);
    chk("restart_busy", {7'b0, busy1}, 8'h01);
    chk("restart_err", {5'b0, err1}, 8'h00);
    chk("restart_fail", {4'b0, fv1}, 8'h00);
    step();
    step();
    step();
    step();
    chk("rep_done", {7'b0, done1}, 8'h01);
    chk("rep_err", {5'b0, err1}, 8'h02);
    chk("rep_fail", {4'b0, fv1}, 8'h06);

    // Reset during the 2nd RUN cycle, then a clean OR sweep
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    chk("mid_running", {7'b0, busy1}, 8'h01);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_ab", {6'b0, a1, b1}, 8'h00);
    chk("mid_busy", {7'b0, busy1}, 8'h00);
    chk("mid_done", {7'b0, done1}, 8'h00);
    chk("mid_pass", {7'b0, pass1}, 8'h00);
    chk("mid_err", {5'b0, err1}, 8'h00);
    chk("mid_fail", {4'b0, fv1}, 8'h00);
    step();
    chk("mid_idle", {7'b0, busy1}, 8'h00);
    gsel = 1'b0;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    step();
    step();
    step();
    chk("clean_done", {7'b0, done1}, 8'h01);
    chk("clean_pass", {7'b0, pass1}, 8'h01);
    chk("clean_err", {5'b0, err1}, 8'h00);

    // out_dut tied low, SETTLE=3: 12-cycle sweep
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    busy_cnt = busy3 ? 1 : 0;
    done_at11 = 1'bx;
    done_at12 = 1'bx;
    for (int i = 1; i <= 13; i++) begin
      step();
      if (busy3) busy_cnt++;
      if (i == 3) chk("s3_ab_v1", {6'b0, a3, b3}, 8'h01);
      if (i == 2) chk("s3_ab_v0", {6'b0, a3, b3}, 8'h00);
      if (i == 11) done_at11 = done3;
      if (i == 12) done_at12 = done3;
    end
    chk("s3_busy_cycles", 8'(busy_cnt), 8'd12);
    chk("s3_done_early", {7'b0, done_at11}, 8'h00);
    chk("s3_done", {7'b0, done_at12}, 8'h01);
    chk("s3_err", {5'b0, err3}, 8'h03);
    chk("s3_fail", {4'b0, fv3}, 8'h0e);
    chk("s3_pass", {7'b0, pass3}, 8'h00);

    // XOR gate, SETTLE=2, against XOR and NAND tables
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int i = 1; i <= 7; i++) step();
    chk("x_done_early", {7'b0, donex}, 8'h00);
    step();
    chk("x_done", {7'b0, donex}, 8'h01);
    chk("x_pass", {7'b0, passx}, 8'h01);
    chk("x_err", {5'b0, errx}, 8'h00);
    chk("x_fail", {4'b0, fvx}, 8'h00);
    chk("n_done", {7'b0, donen}, 8'h01);
    chk("n_pass", {7'b0, passn}, 8'h00);
    // XOR vs NAND differs only at vector 00 (XOR=0, NAND=1)
    chk("n_err", {5'b0, errn}, 8'h01);
    chk("n_fail", {4'b0, fvn}, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
